// File: rtl/router_rx_ctrl.sv
// Router input controller: parses header/payload/parity, steers bytes to one of NPORTS FIFOs through a 2-entry skid.
// Latency: accepted byte reaches dout/wr_en 0..1 cycles after its edge; busy holds the source while the hold reg is full or in CHECK.
module router_rx_ctrl #(
    parameter int DATA_W = 8,
    parameter int NPORTS = 3
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              pkt_valid,
    input  logic [DATA_W-1:0] data_in,
    output logic              busy,
    output logic              error,
    input  logic [NPORTS-1:0] fifo_full,
    output logic [NPORTS-1:0] wr_en,
    output logic [DATA_W-1:0] dout
);

    typedef enum logic [2:0] {IDLE, DATA, PARITY, CHECK, DROP} state_t;

    state_t            state;
    logic [1:0]        addr;
    logic [6:0]        cnt;
    logic [DATA_W-1:0] par;
    logic              parity_ok;

    logic              out_valid;
    logic [1:0]        out_port;
    logic              hold_valid;
    logic [1:0]        hold_port;
    logic [DATA_W-1:0] hold_byte;

    logic              accept;
    logic              hdr_ok;
    logic              to_skid;
    logic              drain;
    logic              hold_nxt;
    logic [1:0]        in_port;

    always_comb begin
        wr_en = '0;
        for (int p = 0; p < NPORTS; p++) begin
            wr_en[p] = out_valid && (out_port == p[1:0]) && !fifo_full[p];
        end
    end

    // busy is high whenever hold is occupied, so an accepted byte never meets a full hold reg.
    always_comb begin
        accept   = pkt_valid && !busy;
        hdr_ok   = 32'(data_in[1:0]) < NPORTS;
        to_skid  = accept && ((state == IDLE && hdr_ok) || state == DATA || state == PARITY);
        drain    = |wr_en;
        in_port  = (state == IDLE) ? data_in[1:0] : addr;
        hold_nxt = (hold_valid && !drain) || (to_skid && out_valid && !drain);
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state      <= IDLE;
            addr       <= '0;
            cnt        <= '0;
            par        <= '0;
            parity_ok  <= 1'b0;
            busy       <= 1'b0;
            error      <= 1'b0;
            out_valid  <= 1'b0;
            out_port   <= '0;
            dout       <= '0;
            hold_valid <= 1'b0;
            hold_port  <= '0;
            hold_byte  <= '0;
        end else begin
            if (drain || !out_valid) begin
                if (hold_valid) begin
                    out_valid <= 1'b1;
                    out_port  <= hold_port;
                    dout      <= hold_byte;
                end else if (to_skid) begin
                    out_valid <= 1'b1;
                    out_port  <= in_port;
                    dout      <= data_in;
                end else begin
                    out_valid <= 1'b0;
                end
            end
            hold_valid <= hold_nxt;
            if (to_skid && out_valid && !drain) begin
                hold_port <= in_port;
                hold_byte <= data_in;
            end

            busy <= hold_nxt || (state == PARITY && accept);

            case (state)
                IDLE: if (accept) begin
                    addr  <= data_in[1:0];
                    par   <= data_in;
                    error <= 1'b0;
                    if (!hdr_ok) begin
                        cnt   <= {1'b0, data_in[7:2]} + 7'd1;
                        state <= DROP;
                    end else if (data_in[7:2] == 6'd0) begin
                        state <= PARITY;
                    end else begin
                        cnt   <= {1'b0, data_in[7:2]};
                        state <= DATA;
                    end
                end
                DATA: if (accept) begin
                    par <= par ^ data_in;
                    cnt <= cnt - 7'd1;
                    if (cnt == 7'd1) state <= PARITY;
                end
                PARITY: if (accept) begin
                    parity_ok <= (par == data_in);
                    state     <= CHECK;
                end
                CHECK: begin
                    error <= ~parity_ok;
                    state <= IDLE;
                end
                DROP: if (accept) begin
                    cnt <= cnt - 7'd1;
                    if (cnt == 7'd1) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_router_rx_ctrl.sv
// Scoreboard bench for router_rx_ctrl: stimulus pushes expected {port,byte}, a negedge monitor pops on every write.
module tb_router_rx_ctrl;

    logic       clock = 1'b0;
    logic       resetn = 1'b0;
    logic       pkt_valid = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic       busy;
    logic       error;
    logic [2:0] fifo_full = 3'b000;
    logic [2:0] wr_en;
    logic [7:0] dout;

    typedef struct packed {
        logic [1:0] port;
        logic [7:0] b;
    } exp_t;

    exp_t q[$];
    int total = 0;
    int bad = 0;

    always #5 clock = ~clock;

    router_rx_ctrl #(.DATA_W(8), .NPORTS(3)) dut (
        .clock     (clock),
        .resetn    (resetn),
        .pkt_valid (pkt_valid),
        .data_in   (data_in),
        .busy      (busy),
        .error     (error),
        .fifo_full (fifo_full),
        .wr_en     (wr_en),
        .dout      (dout)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, req);
        end
    endtask

    // Monitor: every FIFO write must match the oldest outstanding expectation.
    exp_t e;
    always @(negedge clock) begin
        if (resetn && wr_en != 3'b000) begin
            if (q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_write: got wr_en=%0b dout=%0h want no write", wr_en, dout);
            end else begin
                e = q.pop_front();
                check("wr_port", 32'(wr_en), 32'(3'b001 << e.port));
                check("dout", 32'(dout), 32'(e.b));
                check("wr_while_full", 32'(wr_en & fifo_full), 0);
            end
        end
    end

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic send(input logic [7:0] b);
        int n = 0;
        pkt_valid = 1'b1;
        data_in   = b;
        while (busy && n < 100) begin
            @(negedge clock);
            n++;
        end
        if (n >= 100) begin
            total++;
            bad++;
            $display("FAIL send_timeout: got busy stuck for byte %0h want accept", b);
        end
        @(negedge clock);
        pkt_valid = 1'b0;
    endtask

    task automatic send_exp(input logic [1:0] p, input logic [7:0] b);
        q.push_back({p, b});
        send(b);
    endtask

    initial begin
        fork
            begin
                #200000;
                $display("FAIL watchdog: got timeout want finish");
                $fatal(1, "watchdog");
            end
        join_none

        repeat (2) @(negedge clock);
        check("rst_busy", 32'(busy), 0);
        check("rst_error", 32'(error), 0);
        check("rst_wr_en", 32'(wr_en), 0);
        check("rst_dout", 32'(dout), 0);
        resetn = 1'b1;
        @(negedge clock);

        // Good packet to port 1: len 3, parity 0x0D^AA^BB^CC = D0
        send_exp(2'd1, 8'h0D);
        send_exp(2'd1, 8'hAA);
        send_exp(2'd1, 8'hBB);
        send_exp(2'd1, 8'hCC);
        send_exp(2'd1, 8'hD0);
        check("good_busy_check", 32'(busy), 1);
        @(negedge clock);
        check("good_error", 32'(error), 0);
        check("good_busy_after", 32'(busy), 0);
        check("good_drained", q.size(), 0);

        // Bad parity: bytes still written, error raised after CHECK and held
        send_exp(2'd1, 8'h0D);
        send_exp(2'd1, 8'hAA);
        send_exp(2'd1, 8'hBB);
        send_exp(2'd1, 8'hCC);
        send_exp(2'd1, 8'hD1);
        check("bad_busy_check", 32'(busy), 1);
        check("bad_error_in_check", 32'(error), 0);
        @(negedge clock);
        check("bad_error", 32'(error), 1);
        repeat (3) @(negedge clock);
        check("bad_error_held", 32'(error), 1);
        check("bad_drained", q.size(), 0);

        // Reset mid-payload with FIFO full so bytes sit in the skid
        fifo_full = 3'b010;
        send(8'h0D);
        send(8'hAA);
        check("mid_busy_before_rst", 32'(busy), 1);
        #2 resetn = 1'b0;
        #1;
        check("mid_rst_busy", 32'(busy), 0);
        check("mid_rst_error", 32'(error), 0);
        check("mid_rst_wr_en", 32'(wr_en), 0);
        @(negedge clock);
        resetn    = 1'b1;
        fifo_full = 3'b000;
        @(negedge clock);

        // Back-pressure on port 1 from the second payload byte
        send_exp(2'd1, 8'h0D);
        send_exp(2'd1, 8'hAA);
        fifo_full[1] = 1'b1;
        send_exp(2'd1, 8'hBB);
        check("bp_busy_hold", 32'(busy), 1);
        repeat (8) @(negedge clock);
        check("bp_busy_still", 32'(busy), 1);
        check("bp_wr_en_blocked", 32'(wr_en), 0);
        check("bp_pending", q.size(), 2);
        fifo_full[1] = 1'b0;
        send_exp(2'd1, 8'hCC);
        send_exp(2'd1, 8'hD0);
        @(negedge clock);
        check("bp_error", 32'(error), 0);
        repeat (2) @(negedge clock);
        check("bp_drained", q.size(), 0);

        // Invalid address 3: header + len 2 + parity consumed, nothing written
        send(8'h0B);
        send(8'h11);
        send(8'h22);
        send(8'h38);
        check("inv_busy", 32'(busy), 0);
        repeat (2) @(negedge clock);
        check("inv_error", 32'(error), 0);
        check("inv_no_writes", q.size(), 0);

        // Zero-length packet to port 0 with a 3-cycle gap before parity
        send_exp(2'd0, 8'h00);
        repeat (3) @(negedge clock);
        send_exp(2'd0, 8'h00);
        check("zl_busy_check", 32'(busy), 1);
        @(negedge clock);
        check("zl_error", 32'(error), 0);
        repeat (2) @(negedge clock);
        check("zl_drained", q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
